// File: rtl/fir_stream_pkg.sv
// -----------------------------------------------------------------------------
// fir_stream_pkg
// Shared definitions for the FIR output stream stage: default widths, the
// frame-tracking state enum and the FIFO entry layout.
// -----------------------------------------------------------------------------
package fir_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH      = 8;

  // Frame tracker: IDLE between frames, ACTIVE once a non-last beat is taken.
  typedef enum logic {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frame_state_e;

  // One FIFO word at the default sample width. The FIFO re-declares the same
  // layout at its own parameterised width.
  typedef struct packed {
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage : fir_stream_pkg

// File: rtl/fir_axis_fifo.sv
// -----------------------------------------------------------------------------
// fir_axis_fifo
// Registered-storage, first-word-fall-through FIFO carrying {last, data}.
// Write side stalls when full; read side presents the head entry whenever the
// FIFO is non-empty. No empty bypass: a written word is visible next cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_valid/wr_ready   write handshake; wr_ready = not full
//   wr_data, wr_last    word to store
//   rd_valid/rd_ready   read handshake; rd_valid = not empty
//   rd_data, rd_last    head entry
//   level               occupancy 0..pDEPTH
// -----------------------------------------------------------------------------
module fir_axis_fifo
  import fir_stream_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned pDEPTH      = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [pDATA_WIDTH-1:0]   wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [pDATA_WIDTH-1:0]   rd_data,
  output logic                     rd_last,
  input  logic                     rd_ready,
  output logic [$clog2(pDEPTH):0]  level
);

  localparam int unsigned AW = $clog2(pDEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(pDEPTH);

  typedef struct packed {
    logic                   last;
    logic [pDATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem_q [pDEPTH];
  entry_t          mem_d [pDEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            push, pop;

  assign wr_ready = (level_q != FULL_LEVEL);
  assign rd_valid = (level_q != '0);
  assign rd_data  = mem_q[rd_ptr_q].data;
  assign rd_last  = mem_q[rd_ptr_q].last;
  assign level    = level_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    push = wr_valid & wr_ready;
    pop  = rd_valid & rd_ready;

    // Depth is a power of two, so pointers wrap by plain overflow.
    if (push) begin
      mem_d[wr_ptr_q].last = wr_last;
      mem_d[wr_ptr_q].data = wr_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      // NOTE: storage is reset on purpose: it is tiny, and the head word feeds
      // dn_tdata directly, which must read zero out of reset, not X.
      for (int i = 0; i < int'(pDEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

endmodule : fir_axis_fifo

// File: rtl/fir_out_buffer.sv
// -----------------------------------------------------------------------------
// fir_out_buffer
// Elastic AXI-Stream output stage behind the FIR core. Buffers samples in a
// small FIFO, tracks frame boundaries, checks each frame's length against
// data_length and exposes beat/frame counters plus a sticky length error.
//
// Ports
//   axis_clk, axis_rst         clock, asynchronous active-high reset
//   sm_tvalid/tdata/tlast/tready   upstream stream from the FIR core
//   dn_tvalid/tdata/tlast/tready   downstream stream to the consumer
//   data_length                expected beats per frame, sampled per push
//   clr                        synchronous clear of counters/error/FSM
//   busy                       frame in progress
//   frame_done                 1-cycle pulse on a correctly terminated frame
//   len_err                    sticky frame-length error
//   beat_cnt, frame_cnt        beats in current frame, completed frames
//   level                      FIFO occupancy
// -----------------------------------------------------------------------------
module fir_out_buffer
  import fir_stream_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned pDEPTH      = DEF_DEPTH,
  parameter int unsigned pCNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst,
  input  logic                     sm_tvalid,
  input  logic [pDATA_WIDTH-1:0]   sm_tdata,
  input  logic                     sm_tlast,
  output logic                     sm_tready,
  output logic                     dn_tvalid,
  output logic [pDATA_WIDTH-1:0]   dn_tdata,
  output logic                     dn_tlast,
  input  logic                     dn_tready,
  input  logic [pCNT_WIDTH-1:0]    data_length,
  input  logic                     clr,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     len_err,
  output logic [pCNT_WIDTH-1:0]    beat_cnt,
  output logic [pCNT_WIDTH-1:0]    frame_cnt,
  output logic [$clog2(pDEPTH):0]  level
);

  frame_state_e            state_q, state_d;
  logic [pCNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [pCNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic                    len_err_q, len_err_d;
  logic                    frame_done_q, frame_done_d;
  logic                    push;
  logic [pCNT_WIDTH:0]     beat_idx;
  logic                    length_hit;
  logic                    beat_err;

  fir_axis_fifo #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH)
  ) u_fifo (
    .clk      (axis_clk),
    .rst      (axis_rst),
    .wr_valid (sm_tvalid),
    .wr_data  (sm_tdata),
    .wr_last  (sm_tlast),
    .wr_ready (sm_tready),
    .rd_valid (dn_tvalid),
    .rd_data  (dn_tdata),
    .rd_last  (dn_tlast),
    .rd_ready (dn_tready),
    .level    (level)
  );

  assign push = sm_tvalid & sm_tready;

  // Beat index is one bit wider than the counter so a saturated beat_cnt
  // cannot wrap back onto a small data_length.
  assign beat_idx   = {1'b0, beat_cnt_q} + (pCNT_WIDTH+1)'(1);
  assign length_hit = (beat_idx == {1'b0, data_length});
  // Error when tlast arrives off-length, or the expected length passes
  // without tlast: exactly when tlast and length_hit disagree.
  assign beat_err   = sm_tlast ^ length_hit;

  // Frame FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FRAME_IDLE:   if (push && !sm_tlast) state_d = FRAME_ACTIVE;
      FRAME_ACTIVE: if (push &&  sm_tlast) state_d = FRAME_IDLE;
      default:      state_d = FRAME_IDLE;
    endcase
    if (clr) state_d = FRAME_IDLE;
  end

  // Counters, sticky error and done pulse.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    len_err_d    = len_err_q;
    frame_done_d = 1'b0;

    if (clr) begin
      // A push coinciding with clr still lands in the FIFO but is not counted.
      beat_cnt_d  = '0;
      frame_cnt_d = '0;
      len_err_d   = 1'b0;
    end else if (push) begin
      if (beat_err) len_err_d = 1'b1;
      if (sm_tlast) begin
        beat_cnt_d   = '0;
        frame_cnt_d  = frame_cnt_q + pCNT_WIDTH'(1);
        frame_done_d = ~beat_err;
      end else if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + pCNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q      <= FRAME_IDLE;
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      len_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      len_err_q    <= len_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = (state_q == FRAME_ACTIVE);
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;
  assign beat_cnt   = beat_cnt_q;
  assign frame_cnt  = frame_cnt_q;

endmodule : fir_out_buffer

// File: tb/tb_fir_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_fir_out_buffer
// Directed + randomized bench for fir_out_buffer. A queue-based reference
// model holds FIFO contents and per-frame bookkeeping; outputs are compared
// every cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_fir_out_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 32;

  logic            axis_clk = 1'b0;
  logic            axis_rst;
  logic            sm_tvalid;
  logic [DW-1:0]   sm_tdata;
  logic            sm_tlast;
  logic            sm_tready;
  logic            dn_tvalid;
  logic [DW-1:0]   dn_tdata;
  logic            dn_tlast;
  logic            dn_tready;
  logic [CW-1:0]   data_length;
  logic            clr;
  logic            busy;
  logic            frame_done;
  logic            len_err;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   frame_cnt;
  logic [$clog2(DEPTH):0] level;

  always #5 axis_clk = ~axis_clk;

  fir_out_buffer #(
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH),
    .pCNT_WIDTH  (CW)
  ) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .sm_tvalid   (sm_tvalid),
    .sm_tdata    (sm_tdata),
    .sm_tlast    (sm_tlast),
    .sm_tready   (sm_tready),
    .dn_tvalid   (dn_tvalid),
    .dn_tdata    (dn_tdata),
    .dn_tlast    (dn_tlast),
    .dn_tready   (dn_tready),
    .data_length (data_length),
    .clr         (clr),
    .busy        (busy),
    .frame_done  (frame_done),
    .len_err     (len_err),
    .beat_cnt    (beat_cnt),
    .frame_cnt   (frame_cnt),
    .level       (level)
  );

  typedef struct {
    bit            last;
    logic [DW-1:0] data;
  } beat_t;

  // Reference model state.
  beat_t  tx_q[$];     // beats waiting to be offered upstream
  beat_t  m_fifo[$];   // beats held by the buffer, head = next out
  longint m_beats;
  longint m_frames;
  bit     m_err;
  bit     m_busy;
  bit     m_done;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    tx_q.delete();
    m_beats  = 0;
    m_frames = 0;
    m_err    = 0;
    m_busy   = 0;
    m_done   = 0;
  endtask

  task automatic check_all();
    check("sm_tready", 64'(sm_tready), 64'(m_fifo.size() != DEPTH));
    check("dn_tvalid", 64'(dn_tvalid), 64'(m_fifo.size() != 0));
    check("level",     64'(level),     64'(m_fifo.size()));
    if (m_fifo.size() != 0) begin
      check("dn_tdata", 64'(dn_tdata), 64'(m_fifo[0].data));
      check("dn_tlast", 64'(dn_tlast), 64'(m_fifo[0].last));
    end
    check("busy",       64'(busy),       64'(m_busy));
    check("frame_done", 64'(frame_done), 64'(m_done));
    check("len_err",    64'(len_err),    64'(m_err));
    check("beat_cnt",   64'(beat_cnt),   64'(m_beats));
    check("frame_cnt",  64'(frame_cnt),  64'(m_frames));
    if (frame_done === 1'b1) done_seen++;
  endtask

  task automatic add_frame(input int n, input bit with_last);
    beat_t bt;
    for (int i = 1; i <= n; i++) begin
      bt.last = with_last && (i == n);
      bt.data = $urandom();
      tx_q.push_back(bt);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model at the
  // rising edge, then return on the falling edge.
  task automatic step(input bit rdy, input bit try_v, input bit do_clr);
    bit     push, pop, e;
    longint b;
    check_all();
    sm_tvalid = try_v && (tx_q.size() != 0);
    sm_tdata  = (tx_q.size() != 0) ? tx_q[0].data : DW'($urandom());
    sm_tlast  = (tx_q.size() != 0) ? tx_q[0].last : 1'b0;
    dn_tready = rdy;
    clr       = do_clr;
    @(posedge axis_clk);
    push   = sm_tvalid && (m_fifo.size() != DEPTH);
    pop    = (m_fifo.size() != 0) && rdy;
    m_done = 0;
    if (do_clr) begin
      m_beats  = 0;
      m_frames = 0;
      m_err    = 0;
      m_busy   = 0;
    end else if (push) begin
      b = m_beats + 1;
      if (tx_q[0].last) e = (b != longint'(data_length));
      else              e = (b == longint'(data_length));
      if (e) m_err = 1;
      if (tx_q[0].last) begin
        m_beats  = 0;
        m_frames = (m_frames + 1) % 64'h1_0000_0000;
        m_done   = !e;
        m_busy   = 0;
      end else begin
        if (b <= 64'hFFFF_FFFF) m_beats = b;
        m_busy = 1;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      m_fifo.push_back(tx_q[0]);
      void'(tx_q.pop_front());
    end
    @(negedge axis_clk);
  endtask

  // Run until everything offered has left the buffer, within a cycle budget.
  // rdy_mode: 1 = consumer always ready, 2 = random.
  task automatic drain(input string tag, input int max_cycles, input int rdy_mode, output int used);
    int n = 0;
    while ((tx_q.size() != 0 || m_fifo.size() != 0) && n < max_cycles) begin
      step((rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n++;
    end
    used = n;
    check({tag, "_in_budget"}, 64'(n < max_cycles), 64'(1));
    check({tag, "_level"}, 64'(level), 64'(0));
  endtask

  int cyc;

  initial begin
    axis_rst    = 1'b1;
    sm_tvalid   = 1'b0;
    sm_tdata    = '0;
    sm_tlast    = 1'b0;
    dn_tready   = 1'b0;
    data_length = '0;
    clr         = 1'b0;
    model_reset();

    // Reset values.
    #12;
    check_all();
    check("rst_dn_tdata", 64'(dn_tdata), 64'(0));
    check("rst_dn_tlast", 64'(dn_tlast), 64'(0));
    @(negedge axis_clk);
    axis_rst = 1'b0;

    // 600-beat frame at full throughput.
    data_length = 600;
    add_frame(600, 1'b1);
    done_seen = 0;
    drain("t1", 700, 1, cyc);
    check("t1_cycles", 64'(cyc), 64'(601));
    step(1'b1, 1'b0, 1'b0);
    check("t1_done_pulses", 64'(done_seen), 64'(1));
    check("t1_frame_cnt", 64'(frame_cnt), 64'(1));
    check("t1_len_err", 64'(len_err), 64'(0));

    // Back-pressure: fill to 8, push attempt while full, then release.
    data_length = 10;
    add_frame(10, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    check("t2_level_full", 64'(level), 64'(8));
    check("t2_sm_tready_low", 64'(sm_tready), 64'(0));
    step(1'b0, 1'b1, 1'b0);
    check("t2_level_held", 64'(level), 64'(8));
    drain("t2", 40, 1, cyc);
    check("t2_frame_cnt", 64'(frame_cnt), 64'(2));

    // Short frame: tlast on beat 5 with length 6.
    step(1'b1, 1'b0, 1'b1);
    data_length = 6;
    done_seen = 0;
    add_frame(5, 1'b1);
    drain("t3", 40, 1, cyc);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("t3_len_err", 64'(len_err), 64'(1));
    check("t3_no_done", 64'(done_seen), 64'(0));
    check("t3_frame_cnt", 64'(frame_cnt), 64'(1));
    step(1'b1, 1'b0, 1'b1);
    check("t3_clr_len_err", 64'(len_err), 64'(0));

    // Long frame: beat 6 without tlast, then tlast on beat 7.
    add_frame(6, 1'b0);
    drain("t4", 40, 1, cyc);
    check("t4_len_err", 64'(len_err), 64'(1));
    check("t4_busy", 64'(busy), 64'(1));
    check("t4_beat_cnt", 64'(beat_cnt), 64'(6));
    add_frame(1, 1'b1);
    drain("t4b", 40, 1, cyc);
    check("t4_busy_end", 64'(busy), 64'(0));
    step(1'b1, 1'b0, 1'b1);

    // Full with simultaneous push/pop attempt, then half-full push+pop.
    data_length = 100;
    add_frame(20, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t5_full_pushpop", 64'(level), 64'(7));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("t5_half", 64'(level), 64'(4));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("t5_half_pushpop", 64'(level), 64'(4));
    end
    drain("t5", 60, 1, cyc);
    step(1'b1, 1'b0, 1'b1);

    // Randomized traffic: mixed frame lengths, data_length, back-pressure,
    // idle gaps and occasional clr.
    for (int i = 0; i < 2000; i++) begin
      if (tx_q.size() < 4) add_frame($urandom_range(1, 10), 1'b1);
      if ($urandom_range(0, 49) == 0) data_length = $urandom_range(0, 10);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 199) == 0));
    end
    drain("rnd", 300, 2, cyc);

    // Reset mid-frame with four words buffered.
    step(1'b1, 1'b0, 1'b1);
    data_length = 50;
    add_frame(10, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    check("t6_level_pre", 64'(level), 64'(4));
    check("t6_busy_pre", 64'(busy), 64'(1));
    #2 axis_rst = 1'b1;
    #1;
    check("t6_dn_tvalid", 64'(dn_tvalid), 64'(0));
    check("t6_level", 64'(level), 64'(0));
    check("t6_beat_cnt", 64'(beat_cnt), 64'(0));
    check("t6_frame_cnt", 64'(frame_cnt), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_sm_tready", 64'(sm_tready), 64'(1));
    check("t6_dn_tdata", 64'(dn_tdata), 64'(0));
    model_reset();
    @(negedge axis_clk);
    axis_rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fir_out_buffer
